spi_rx: RTL and testbench

- Serial receiver that consumes the sclk/mosi pair produced by spi_tx.
- Reassembles LSB-first 8-bit frames and presents each completed byte as a one-cycle Option<uint<8>> pulse.
- Sits directly downstream of spi_tx: in loopback benches and on the peripheral side of the link.
- Asynchronous line inputs are synchronised into the single system clock domain before use.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_line_sync.sv | 29 ++
 rtl/spi_rx.sv | 125 ++++++++++++
 tb/tb_spi_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI link: frame geometry, the Option<uint<8>>
// encoding used on the receiver output, and the receiver state enum.
package spi_pkg;

  localparam int BITS_PER_FRAME = 8;
  localparam logic OPTION_NONE_TAG = 1'b1;

  localparam int RX_BYTE_LSB = 2;
  localparam int BUSY_BIT = 1;
  localparam int ERR_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } rx_state_e;

  typedef struct packed {
    logic                      tag;
    logic [BITS_PER_FRAME-1:0] payload;
  } opt_byte_t;

  function automatic opt_byte_t opt_none();
    return {OPTION_NONE_TAG, {BITS_PER_FRAME{1'b0}}};
  endfunction

  function automatic opt_byte_t opt_some(input logic [BITS_PER_FRAME-1:0] value);
    return {~OPTION_NONE_TAG, value};
  endfunction

endpackage

// File: rtl/spi_line_sync.sv
// Multi-flop synchroniser for one asynchronous line, resetting to 1 so an idle-high
// line never looks like a falling edge; also emits a registered falling-edge strobe.
module spi_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;

  // level lags the synchronised value by one cycle so it lines up with fall,
  // letting a data line sampled alongside this strobe be read in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], line};
      level <= chain[SYNC_STAGES-1];
      fall  <= level & ~chain[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/spi_rx.sv
// LSB-first 8-bit SPI receiver emitting each byte as a one-cycle Option<uint<8>> pulse.
// Define SPI_RX_TIMEOUT_EN to build the mid-frame timeout abort and frame_err.
module spi_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic        _i_clk,
  input  logic        _i_rst,
  input  logic        _i_sclk,
  input  logic        _i_mosi,
  output logic [10:0] __output
);

  localparam int CNT_W = $clog2(BITS_PER_FRAME + 1);

  logic sclk_fall;
  logic sclk_level_unused;
  logic mosi_bit;
  logic mosi_fall_unused;

  rx_state_e                 state;
  logic [BITS_PER_FRAME-1:0] shift_reg;
  logic [BITS_PER_FRAME-1:0] shifted;
  logic [CNT_W-1:0]          bit_cnt;
  opt_byte_t                 rx_byte;
  logic                      busy;
  logic                      frame_err;

  spi_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk   (_i_clk),
    .rst   (_i_rst),
    .line  (_i_sclk),
    .level (sclk_level_unused),
    .fall  (sclk_fall)
  );

  spi_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk   (_i_clk),
    .rst   (_i_rst),
    .line  (_i_mosi),
    .level (mosi_bit),
    .fall  (mosi_fall_unused)
  );

  assign shifted = {mosi_bit, shift_reg[BITS_PER_FRAME-1:1]};

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  // TIMEOUT_CYCLES has no effect without the abort path.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign frame_err = 1'b0;
`endif

  // An edge arriving in DONE starts the next frame immediately, so DONE shares
  // the IDLE entry path; rx_byte stays Some for that DONE cycle regardless.
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      rx_byte   <= opt_none();
      busy      <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
`endif
    end else begin
      rx_byte <= opt_none();
`ifdef SPI_RX_TIMEOUT_EN
      frame_err <= 1'b0;
      if (sclk_fall || state != RECV) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + 1'b1;
`endif
      case (state)
        IDLE, DONE: begin
          if (sclk_fall) begin
            shift_reg <= shifted;
            bit_cnt   <= CNT_W'(1);
            busy      <= 1'b1;
            state     <= RECV;
          end else begin
            state <= IDLE;
          end
        end
        RECV: begin
          if (sclk_fall) begin
            shift_reg <= shifted;
            if (bit_cnt == CNT_W'(BITS_PER_FRAME - 1)) begin
              bit_cnt <= '0;
              busy    <= 1'b0;
              rx_byte <= opt_some(shifted);
              state   <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`ifdef SPI_RX_TIMEOUT_EN
          else if (tmo_hit) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            state     <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign __output[RX_BYTE_LSB +: BITS_PER_FRAME + 1] = rx_byte;
  assign __output[BUSY_BIT]                          = busy;
  assign __output[ERR_BIT]                           = frame_err;

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: drives sclk/mosi like spi_tx and scoreboards every
// Some pulse (payload and arrival cycle) and every frame_err pulse.
module tb_spi_rx;

  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int LAT            = SYNC_STAGES + 2;
  localparam logic [10:0] IDLE_OUT = 11'b100_0000_0000;

  typedef struct {
    logic [7:0] data;
    int         half;
    bit         glitch;
    bit         chk_busy;
  } vec_t;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        sclk = 1'b1;
  logic        mosi = 1'b0;
  logic [10:0] dut_out;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   last_fall_cyc = 0;
  int   got_data[$];
  int   got_cyc[$];
  int   exp_data[$];
  int   exp_cyc[$];
  int   err_cyc[$];
  vec_t vecs[6];

  spi_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    ._i_clk   (clk),
    ._i_rst   (rst),
    ._i_sclk  (sclk),
    ._i_mosi  (mosi),
    .__output (dut_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut_out[10] === 1'b0) begin
      got_data.push_back(int'(dut_out[9:2]));
      got_cyc.push_back(cyc);
    end
    if (dut_out[0] === 1'b1) err_cyc.push_back(cyc);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Sends bits [first +: count] of data LSB first; each bit is half cycles high
  // then half cycles low. Must be entered on a falling clk edge with sclk high.
  task automatic applyStimulus(input logic [7:0] data, input int first, input int count,
                               input int half, input bit glitch, input bit chk_busy);
    for (int b = first; b < first + count; b++) begin
      mosi = data[b];
      repeat (half) @(negedge clk);
      sclk = 1'b0;
      last_fall_cyc = cyc;
      for (int j = 1; j <= half; j++) begin
        @(negedge clk);
        if (chk_busy && b == first && j == LAT - 1) checkOutput("busy_before_edge", 32'(dut_out[1]), 0);
        if (chk_busy && b == first && j == LAT)     checkOutput("busy_after_edge", 32'(dut_out[1]), 1);
        if (glitch && j < half) mosi = ~mosi;
      end
      sclk = 1'b1;
    end
  endtask

  task automatic checkScoreboard(input string tag);
    checkOutput($sformatf("%s_some_count", tag), got_data.size(), exp_data.size());
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checkOutput($sformatf("%s_byte%0d", tag, i), got_data[i], exp_data[i]);
      checkOutput($sformatf("%s_cycle%0d", tag, i), got_cyc[i], exp_cyc[i]);
    end
    got_data.delete();
    got_cyc.delete();
    exp_data.delete();
    exp_cyc.delete();
  endtask

  initial begin
    int bad;
`ifdef SPI_RX_TIMEOUT_EN
    int exp_err;
`endif
    vecs[0] = '{8'hB2, 500, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 500, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 500, 1'b0, 1'b0};
    vecs[3] = '{8'h0F, 20,  1'b1, 1'b0};
    vecs[4] = '{8'hA5, 1,   1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1,   1'b0, 1'b0};

    repeat (5) @(negedge clk);
    checkOutput("reset_state", 32'(dut_out), 32'(IDLE_OUT));
    rst = 1'b0;

    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (dut_out !== IDLE_OUT) bad++;
    end
    checkOutput("idle_bad_cycles", bad, 0);
    checkOutput("idle_output", 32'(dut_out), 32'(IDLE_OUT));

    $display("[TB] table of %0d frames", $size(vecs));
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, 0, 8, vecs[i].half, vecs[i].glitch, vecs[i].chk_busy);
      exp_data.push_back(int'(vecs[i].data));
      exp_cyc.push_back(last_fall_cyc + LAT);
    end
    repeat (20) @(negedge clk);
    if (got_cyc.size() >= 3) checkOutput("b2b_spacing", got_cyc[2] - got_cyc[1], 8000);
    else                     checkOutput("b2b_frames_seen", got_cyc.size(), 3);
    checkOutput("busy_after_table", 32'(dut_out[1]), 0);
    checkScoreboard("table");
    checkOutput("table_err_count", err_cyc.size(), 0);

`ifdef SPI_RX_TIMEOUT_EN
    $display("[TB] partial frame with timeout abort");
    applyStimulus(8'hFF, 0, 3, 20, 1'b0, 1'b0);
    exp_err = last_fall_cyc + LAT + TIMEOUT_CYCLES;
    repeat (5) @(negedge clk);
    checkOutput("busy_partial", 32'(dut_out[1]), 1);
    while (cyc < exp_err + 5) @(negedge clk);
    checkOutput("timeout_err_count", err_cyc.size(), 1);
    if (err_cyc.size() >= 1) checkOutput("timeout_err_cycle", err_cyc[0], exp_err);
    checkOutput("busy_after_timeout", 32'(dut_out[1]), 0);
    checkScoreboard("timeout_partial");
    err_cyc.delete();
    applyStimulus(8'h5A, 0, 8, 20, 1'b0, 1'b0);
    exp_data.push_back(32'h5A);
    exp_cyc.push_back(last_fall_cyc + LAT);
    repeat (20) @(negedge clk);
    checkScoreboard("after_timeout");
`else
    $display("[TB] partial frame held without timeout");
    applyStimulus(8'h5A, 0, 3, 20, 1'b0, 1'b0);
    repeat (TIMEOUT_CYCLES + LAT + 10) @(negedge clk);
    checkOutput("busy_held", 32'(dut_out[1]), 1);
    checkOutput("held_err_count", err_cyc.size(), 0);
    checkScoreboard("held_partial");
    applyStimulus(8'h5A, 3, 5, 20, 1'b0, 1'b0);
    exp_data.push_back(32'h5A);
    exp_cyc.push_back(last_fall_cyc + LAT);
    repeat (20) @(negedge clk);
    checkScoreboard("held_complete");
`endif

    $display("[TB] reset in mid-frame");
    applyStimulus(8'hC3, 0, 5, 20, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("busy_before_reset", 32'(dut_out[1]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("output_after_reset", 32'(dut_out), 32'(IDLE_OUT));
    repeat (5) @(negedge clk);
    applyStimulus(8'hC3, 0, 8, 20, 1'b0, 1'b0);
    exp_data.push_back(32'hC3);
    exp_cyc.push_back(last_fall_cyc + LAT);
    repeat (20) @(negedge clk);
    checkScoreboard("after_reset");
    checkOutput("final_err_count", err_cyc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
